// File: rtl/slave_port.sv
// Slave-side endpoint of the serial system bus.
// Deserialises address/mode/write data (LSB first), performs one parallel
// memory access, and serialises read data back to the master.
module slave_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_ren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid
);

    // One bit counter serves every serial field, so size it for the widest.
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int TW   = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        MEMWR,
        MEMRD,
        RDATA
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [TW-1:0]         tmo_q,   tmo_d;
    logic                  mode_q,  mode_d;

    // State and datapath registers; reset discards any partial transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and field capture; mvalid only matters in IDLE/ADDR/WDATA.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (mvalid) begin
                    addr_d[0] = swdata;
                    cnt_d     = CW'(1);
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (mvalid) begin
                    for (int i = 0; i < ADDR_WIDTH; i++)
                        if (cnt_q == CW'(i)) addr_d[i] = swdata;
                    if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                        cnt_d  = '0;
                        mode_d = smode;
                        if (smode) begin
                            state_d = WDATA;
                        end else begin
                            state_d = MEMRD;
                            tmo_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    for (int i = 0; i < DATA_WIDTH; i++)
                        if (cnt_q == CW'(i)) wdata_d[i] = swdata;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        cnt_d = '0;
                        // Only writes reach WDATA; the mode check is a guard.
                        state_d = mode_q ? MEMWR : IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            MEMWR: begin
                state_d = IDLE;
            end
            MEMRD: begin
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    cnt_d   = '0;
                    state_d = RDATA;
                end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                    // Abandon the read with zero data so the master never stalls.
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = RDATA;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RDATA: begin
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial read bit: rdata indexed by the shared counter.
    always_comb begin
        srdata = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++)
            if (cnt_q == CW'(i)) srdata = rdata_q[i];
    end

    assign sready    = (state_q == IDLE);
    assign mem_wen   = (state_q == MEMWR);
    assign mem_ren   = (state_q == MEMRD);
    assign svalid    = (state_q == RDATA);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_slave_port.sv
// Bench for slave_port: directed vector table, randomized transactions
// against a transaction-level model, and a mid-transfer reset sequence.
module tb_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          swdata = 1'b0;
    logic          smode = 1'b0;
    logic          mvalid = 1'b0;
    logic          srdata, svalid, sready, mem_wen, mem_ren, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .swdata(swdata), .smode(smode), .mvalid(mvalid),
        .srdata(srdata), .svalid(svalid), .sready(sready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: rvalid arrives 'lat' cycles after mem_ren rises.
    int ren_cnt = 0;
    int lat = 0;
    always @(posedge clk) ren_cnt <= mem_ren ? ren_cnt + 1 : 0;
    assign mem_rvalid = mem_ren && (ren_cnt == lat);

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          mode;
        int            lat;
        int            gapm;      // 0 none, 1 random, 2 fixed (3 after addr bit 4, 1 after data bit 2)
        logic          junk;      // toggle mvalid while the port is busy
        int            exp_gap;   // expected extra write latency, -1 = whatever gaps were inserted
        int            exp_ren;   // expected mem_ren cycles
        logic [DW-1:0] exp_rword; // expected serial read word
    } vec_t;

    int passed = 0;
    int total  = 0;

    int            wen_n, wen_cyc, ren_n, ren_first, sv_n, sv_first, sv_last;
    logic [AW-1:0] wen_addr;
    logic [DW-1:0] wen_data, rword;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    task automatic clr();
        wen_n = 0; wen_cyc = -1; ren_n = 0; ren_first = -1;
        sv_n = 0; sv_first = -1; sv_last = -1;
        wen_addr = '0; wen_data = '0; rword = '0;
    endtask

    // Advance to the next falling edge and log what the DUT shows there.
    task automatic tick();
        @(negedge clk);
        if (mem_wen) begin
            wen_n++; wen_cyc = cyc; wen_addr = mem_addr; wen_data = mem_wdata;
        end
        if (mem_ren) begin
            if (ren_n == 0) ren_first = cyc;
            ren_n++;
        end
        if (svalid) begin
            rword = {srdata, rword[DW-1:1]};
            if (sv_n == 0) sv_first = cyc;
            sv_last = cyc;
            sv_n++;
        end
    endtask

    // Shift out address (and data for writes) LSB first, with optional gaps.
    task automatic send(input vec_t v, output int gaps, output int start_c, output int last_c);
        logic [AW+DW-1:0] stream;
        int nb;
        stream  = {v.data, v.addr};
        nb      = AW + (v.mode ? DW : 0);
        gaps    = 0;
        smode   = v.mode;
        start_c = cyc;
        for (int i = 0; i < nb; i++) begin
            int ng;
            mvalid = 1'b1;
            swdata = stream[0];
            stream = stream >> 1;
            tick();
            ng = 0;
            if (i != nb - 1) begin
                if (v.gapm == 1 && $urandom_range(0, 3) == 0) ng = $urandom_range(1, 3);
                if (v.gapm == 2 && i == 4) ng = 3;
                if (v.gapm == 2 && i == AW + 2) ng = 1;
            end
            for (int g = 0; g < ng; g++) begin
                mvalid = 1'b0;
                swdata = 1'($urandom);
                tick();
                gaps++;
            end
        end
        mvalid = 1'b0;
        last_c = cyc;
    endtask

    // Run until sready is seen; returns on that falling edge (first IDLE cycle).
    task automatic wait_idle(input logic junk, output int rc);
        int n;
        n = 0;
        while (!sready && n < 100) begin
            mvalid = junk ? 1'($urandom) : 1'b0;
            swdata = 1'($urandom);
            tick();
            n++;
        end
        mvalid = 1'b0;
        if (!sready) chk("idle_timeout", 0, 1);
        rc = cyc;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int gaps, start_c, last_c, rc;
        lat       = v.lat;
        mem_rdata = v.mode ? DW'($urandom) : v.data;
        clr();
        send(v, gaps, start_c, last_c);
        wait_idle(v.junk, rc);
        if (v.mode) begin
            chk({tag, " wen_count"}, wen_n, 1);
            chk({tag, " wen_addr"}, int'(wen_addr), int'(v.addr));
            chk({tag, " wen_data"}, int'(wen_data), int'(v.data));
            chk({tag, " wen_latency"}, wen_cyc - start_c,
                AW + DW + ((v.exp_gap < 0) ? gaps : v.exp_gap));
            chk({tag, " ready_after_wen"}, rc, wen_cyc + 1);
            chk({tag, " no_ren"}, ren_n, 0);
        end else begin
            chk({tag, " no_wen"}, wen_n, 0);
            chk({tag, " ren_cycles"}, ren_n, v.exp_ren);
            chk({tag, " ren_start"}, ren_first, last_c);
            chk({tag, " sv_count"}, sv_n, DW);
            chk({tag, " sv_start"}, sv_first, ren_first + v.exp_ren);
            chk({tag, " sv_contig"}, sv_last - sv_first, DW - 1);
            chk({tag, " rword"}, int'(rword), int'(v.exp_rword));
            chk({tag, " ready_after_rd"}, rc, sv_last + 1);
        end
    endtask

    // Transaction-level expectation for a random transaction.
    function automatic vec_t mk_rand();
        vec_t v;
        v.addr      = AW'($urandom);
        v.data      = DW'($urandom);
        v.mode      = 1'($urandom);
        v.lat       = $urandom_range(0, 18);
        v.gapm      = 1;
        v.junk      = 1'($urandom);
        v.exp_gap   = -1;
        v.exp_ren   = (v.lat < TO) ? v.lat + 1 : TO;
        v.exp_rword = (v.lat < TO) ? v.data : '0;
        return v;
    endfunction

    initial begin
        vec_t vt[8];
        vec_t v;
        int   rc;
        logic [AW+DW-1:0] stream;

        vt[0] = '{12'h5A3, 8'hC6, 1'b1, 0,  0, 1'b0,  0, 0,  8'h00}; // contiguous write
        vt[1] = '{12'h0F0, 8'h3C, 1'b0, 2,  0, 1'b0,  0, 3,  8'h3C}; // read, rvalid after 2
        vt[2] = '{12'h5A3, 8'hC6, 1'b1, 0,  2, 1'b0,  4, 0,  8'h00}; // gapped write
        vt[3] = '{12'h001, 8'hFF, 1'b0, 99, 0, 1'b0,  0, 15, 8'h00}; // read timeout
        vt[4] = '{12'h010, 8'h81, 1'b0, 0,  0, 1'b1,  0, 1,  8'h81}; // same-cycle rvalid, junk mvalid
        vt[5] = '{12'h3C7, 8'h5E, 1'b1, 0,  0, 1'b1,  0, 0,  8'h00}; // back-to-back write
        vt[6] = '{12'hABC, 8'h96, 1'b0, 14, 0, 1'b0,  0, 15, 8'h96}; // rvalid on last allowed cycle
        vt[7] = '{12'h800, 8'h77, 1'b0, 15, 0, 1'b0,  0, 15, 8'h00}; // rvalid one cycle too late

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst sready", int'(sready), 1);
        chk("rst outs", int'({mem_wen, mem_ren, svalid, srdata}), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        chk("rst mem_wdata", int'(mem_wdata), 0);

        for (int i = 0; i < 8; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) run_txn(mk_rand(), $sformatf("rand%0d", i));

        // Reset after 4 data bits of a write: nothing reaches memory.
        clr();
        smode  = 1'b1;
        stream = {8'hE9, 12'h6B5};
        for (int i = 0; i < AW + 4; i++) begin
            mvalid = 1'b1;
            swdata = stream[0];
            stream = stream >> 1;
            tick();
        end
        mvalid = 1'b0;
        rst    = 1'b1;
        tick();
        rst    = 1'b0;
        chk("midrst sready", int'(sready), 1);
        chk("midrst outs", int'({mem_wen, mem_ren, svalid, srdata}), 0);
        chk("midrst mem_addr", int'(mem_addr), 0);
        chk("midrst mem_wdata", int'(mem_wdata), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("midrst no_wen", wen_n, 0);
        wait_idle(1'b0, rc);
        v = '{12'h7FF, 8'hA5, 1'b1, 0, 0, 1'b0, 0, 0, 8'h00};
        run_txn(v, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Slave-side endpoint of the serial system bus, directly downstream of the master port.
- Deserialises the slave memory address (LSB first), the transfer mode and, for writes, the write data. It then performs a single access on a parallel memory interface.
- For reads, it serialises the returned word back to the master using svalid-qualified bits, LSB first.
- The address decoder routes the serial lines here only after this slave has been selected. The device-address bits are never seen by this block.

Parameters:
- ADDR_WIDTH, 12, slave memory address width in bits; must be >= 2.
- DATA_WIDTH, 8, data word width in bits; must be >= 2.
- RD_TIMEOUT, 15, maximum number of cycles spent waiting for mem_rvalid before the read is abandoned.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- swdata  in  1  serial address/write-data bit from the bus.
- smode  in  1  transfer mode from the master: 0 = read, 1 = write. Stable for the whole transaction.
- mvalid  in  1  swdata bit is valid this cycle.
- srdata  out  1  serial read-data bit to the master.
- svalid  out  1  srdata is valid this cycle.
- sready  out  1  high when the port is idle and can accept a new transaction.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wen  out  1  memory write strobe.
- mem_ren  out  1  memory read request.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_rvalid  in  1  mem_rdata is valid this cycle.

Behaviour:
- Reset: state = IDLE; the addr, wdata, rdata, bit counter and timeout counter are all 0. All outputs are 0 except sready = 1.
- Reset asserted mid-transaction aborts the transaction with no memory access. A partly received transfer is discarded.
- Bit sampling: a bit is taken only on a rising edge where mvalid = 1. Gaps in mvalid are allowed anywhere in the address or write-data phases. The counter holds during a gap.
- Bit n of any field is stored at index n (LSB first).
- Outputs are Moore, decoded from registered state:
  - sready = (state == IDLE)
  - mem_wen = (state == MEMWR)
  - mem_ren = (state == MEMRD)
  - svalid = (state == RDATA)
  - srdata = rdata[counter]
  - mem_addr and mem_wdata are driven directly from their registers.
- IDLE:
  - If mvalid: addr[0] <= swdata, counter <= 1, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR:
  - On mvalid: addr[counter] <= swdata.
  - When counter == ADDR_WIDTH-1: counter <= 0, latch smode into the mode register, then go to WDATA if smode = 1, else to MEMRD (timeout counter <= 0).
- WDATA:
  - On mvalid: wdata[counter] <= swdata.
  - When counter == DATA_WIDTH-1: counter <= 0, go to MEMWR.
- MEMWR: occupies exactly one cycle (mem_wen = 1), then goes to IDLE. Write latency is 1 cycle after the edge that samples the last data bit.
- MEMRD:
  - mem_ren is held high until mem_rvalid is sampled. A combinational same-cycle mem_rvalid is legal.
  - On mem_rvalid: rdata <= mem_rdata, counter <= 0, go to RDATA.
  - Otherwise the timeout counter increments. When it equals RD_TIMEOUT-1 without mem_rvalid: rdata <= 0, go to RDATA, so the master is never stalled.
  - The minimum time in MEMRD is 1 cycle.
- RDATA:
  - svalid = 1 for exactly DATA_WIDTH consecutive cycles, with srdata = rdata[0] through rdata[DATA_WIDTH-1] in that order.
  - The counter increments every cycle. At counter == DATA_WIDTH-1: counter <= 0, go to IDLE.
- mvalid is ignored in MEMWR, MEMRD and RDATA. No bits are captured and there is no state change.
- A new transaction may begin on the first cycle back in IDLE. Back-to-back transactions therefore have no dead cycle beyond IDLE itself.

Test Plan (defaults ADDR_WIDTH=12, DATA_WIDTH=8, RD_TIMEOUT=15):
1. Write, contiguous: mvalid high for 20 cycles, sending address 0x5A3 then data 0xC6 LSB first, smode=1. Required: mem_wen is high exactly one cycle, in the cycle after the 20th sampling edge, with mem_addr=0x5A3 and mem_wdata=0xC6. sready=1 on the following cycle.
2. Read: address 0x0F0, smode=0; memory asserts mem_rvalid with 0x3C two cycles after mem_ren rises. Required: mem_ren is high for 3 cycles. Then svalid is high for 8 consecutive cycles with srdata = 0,0,1,1,1,1,0,0. Then IDLE.
3. Gapped bits: the write from scenario 1 with mvalid dropped for 3 cycles after address bit 4 and for 1 cycle after data bit 2. Required: identical memory write (0x5A3/0xC6), with mem_wen delayed by 4 cycles.
4. Read timeout: address 0x001, mem_rvalid held at 0. Required: mem_ren is high for 15 cycles then drops. Then 8 svalid cycles with srdata all 0. Then sready=1.
5. Reset mid-WDATA: rst pulsed for 1 cycle after 4 data bits have been received. Required: mem_wen is never asserted, all registers are 0 and sready=1 the cycle after reset. A following write of 0x7FF/0xA5 completes correctly.
6. Ignored mvalid plus back-to-back: mvalid toggles during RDATA of a read of 0x010 (data 0x81). Required: the serial output is unaffected (1,0,0,0,0,0,0,1). A write started on the first IDLE cycle afterwards is captured correctly.
